// File: rtl/adder_tree_pkg.sv
// -----------------------------------------------------------------------------
// adder_tree_pkg
//   Shared helpers for the adder tree and the multiplier array feeding it.
//   - clog2(v)            : ceiling log2, usable in constant expressions
//   - tree_levels(lanes)  : number of registered adder levels for a lane count
//   - lane_width(dw, k)   : bit width of one lane after k adder levels
//   - tree_pairs(lanes,k) : number of adder pairs in level k
// -----------------------------------------------------------------------------
package adder_tree_pkg;

  // Bounded loop so the function stays a legal constant function.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int tree_levels(input int lanes);
    return clog2(lanes);
  endfunction

  // Each level adds one growth bit, so no sum inside the tree can overflow.
  function automatic int lane_width(input int dw, input int k);
    return dw + k;
  endfunction

  function automatic int tree_pairs(input int lanes, input int k);
    return lanes >> (k + 1);
  endfunction

endpackage : adder_tree_pkg

// File: rtl/adder_tree_level.sv
// -----------------------------------------------------------------------------
// adder_tree_level
//   One registered level of the adder tree: PAIRS signed pairwise adders, each
//   sign-extending its IN_W-bit operands to IN_W+1 bits, plus the valid/first/
//   last sideband that travels with the data.
// Ports
//   clock_i    in   rising-edge clock
//   reset_ni   in   asynchronous active-low reset
//   enable_i   in   1 = capture new data, 0 = hold everything
//   valid_i    in   beat valid (sideband)
//   first_i    in   first beat of a sum (sideband)
//   last_i     in   last beat of a sum (sideband)
//   data_i     in   2*PAIRS lanes of IN_W bits, lane 0 in the LSBs
//   valid_o    out  registered valid
//   first_o    out  registered first
//   last_o     out  registered last
//   data_o     out  PAIRS lanes of IN_W+1 bits, lane p = in[2p] + in[2p+1]
// -----------------------------------------------------------------------------
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int PAIRS = 4
) (
  input  logic                            clock_i,
  input  logic                            reset_ni,
  input  logic                            enable_i,
  input  logic                            valid_i,
  input  logic                            first_i,
  input  logic                            last_i,
  input  logic [2*PAIRS*IN_W-1:0]         data_i,
  output logic                            valid_o,
  output logic                            first_o,
  output logic                            last_o,
  output logic [PAIRS*lane_width(IN_W,1)-1:0] data_o
);

  localparam int OUT_W = lane_width(IN_W, 1);

  logic [PAIRS*OUT_W-1:0] sum_d;
  logic [PAIRS*OUT_W-1:0] sum_q;
  logic                   valid_q;
  logic                   first_q;
  logic                   last_q;

  for (genvar p = 0; p < PAIRS; p++) begin : g_pair
    logic signed [IN_W-1:0] op_a;
    logic signed [IN_W-1:0] op_b;
    assign op_a = data_i[(2*p)*IN_W +: IN_W];
    assign op_b = data_i[(2*p+1)*IN_W +: IN_W];
    // Signed size casts sign-extend before the add.
    assign sum_d[p*OUT_W +: OUT_W] = OUT_W'(op_a) + OUT_W'(op_b);
  end

  // Data registers advance on every enabled cycle, bubbles included; only the
  // valid sideband decides whether the accumulator uses the value.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (enable_i) begin
      sum_q   <= sum_d;
      valid_q <= valid_i;
      first_q <= first_i;
      last_q  <= last_i;
    end
  end

  assign data_o  = sum_q;
  assign valid_o = valid_q;
  assign first_o = first_q;
  assign last_o  = last_q;

endmodule : adder_tree_level

// File: rtl/adder_tree_acc_pipe.sv
// -----------------------------------------------------------------------------
// adder_tree_acc_pipe
//   Pipelined signed adder tree (LEVELS = log2(TREE_SIZE) register stages)
//   followed by a one-register multi-beat accumulator. Kernels larger than the
//   tree stream in as several beats framed by in_first / in_last.
//
//   Handshake: there is no back-pressure. A beat is accepted on a rising edge
//   when enable=1 and in_valid=1; in_first/in_last are meaningful only then.
//   out_valid is a one-enabled-cycle pulse; out/out_sat hold until the next
//   completed sum. enable=0 freezes every register, out_valid included.
//
//   Optional feature macro: ADDER_TREE_ACC_SAT_EN
//     defined     : out = acc clamped to the signed OUT_WIDTH range, out_sat
//                   flags a clamp and is registered with out.
//     not defined : out = acc[OUT_WIDTH-1:0] (wrap), out_sat tied to 0.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   enable     in   1 = pipeline advances, 0 = full stall
//   in_valid   in   beat on in is valid
//   in_first   in   first beat of a sum
//   in_last    in   last beat of a sum
//   in         in   TREE_SIZE lanes of DATA_WIDTH, lane 0 in the LSBs
//   out_valid  out  completed-sum pulse
//   out        out  completed signed sum
//   out_sat    out  out was clamped
// -----------------------------------------------------------------------------
module adder_tree_acc_pipe
  import adder_tree_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TREE_SIZE  = 8,
  parameter int ACC_WIDTH  = 48,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            in_valid,
  input  logic                            in_first,
  input  logic                            in_last,
  input  logic [TREE_SIZE*DATA_WIDTH-1:0] in,
  output logic                            out_valid,
  output logic [OUT_WIDTH-1:0]            out,
  output logic                            out_sat
);

  localparam int LEVELS = tree_levels(TREE_SIZE);
  localparam int SUM_W  = lane_width(DATA_WIDTH, LEVELS);

  // Sideband per level boundary: index 0 is the input, index LEVELS is the
  // tree output seen by the accumulator.
  logic [LEVELS:0] lvl_valid;
  logic [LEVELS:0] lvl_first;
  logic [LEVELS:0] lvl_last;

  assign lvl_valid[0] = in_valid;
  assign lvl_first[0] = in_first;
  assign lvl_last[0]  = in_last;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int IN_W  = lane_width(DATA_WIDTH, k);
    localparam int PAIRS = tree_pairs(TREE_SIZE, k);

    logic [2*PAIRS*IN_W-1:0]     d_in;
    logic [PAIRS*(IN_W+1)-1:0]   d_out;

    if (k == 0) begin : g_src
      assign d_in = in;
    end else begin : g_src
      assign d_in = g_lvl[k-1].d_out;
    end

    adder_tree_level #(
      .IN_W  (IN_W),
      .PAIRS (PAIRS)
    ) u_level (
      .clock_i  (clock),
      .reset_ni (reset),
      .enable_i (enable),
      .valid_i  (lvl_valid[k]),
      .first_i  (lvl_first[k]),
      .last_i   (lvl_last[k]),
      .data_i   (d_in),
      .valid_o  (lvl_valid[k+1]),
      .first_o  (lvl_first[k+1]),
      .last_o   (lvl_last[k+1]),
      .data_o   (d_out)
    );
  end

  // ---------------------------------------------------------------------------
  // Accumulator / output stage
  // ---------------------------------------------------------------------------
  logic signed [SUM_W-1:0]     tree_sum;
  logic        [ACC_WIDTH-1:0] tree_ext;
  logic        [ACC_WIDTH-1:0] acc_d;
  logic        [ACC_WIDTH-1:0] acc_q;
  logic                        emit;
  logic        [OUT_WIDTH-1:0] out_red;
  logic        [OUT_WIDTH-1:0] out_d;
  logic        [OUT_WIDTH-1:0] out_q;
  logic                        out_valid_q;

  assign tree_sum = g_lvl[LEVELS-1].d_out;
  assign tree_ext = ACC_WIDTH'(tree_sum);
  assign emit     = lvl_valid[LEVELS] & lvl_last[LEVELS];

  // A first beat restarts the sum, silently dropping any open partial sum.
  // The add wraps modulo 2^ACC_WIDTH by construction.
  always_comb begin
    acc_d = acc_q;
    if (lvl_valid[LEVELS]) begin
      if (lvl_first[LEVELS]) acc_d = tree_ext;
      else                   acc_d = acc_q + tree_ext;
    end
  end

`ifdef ADDER_TREE_ACC_SAT_EN
  logic [ACC_WIDTH-OUT_WIDTH:0] acc_hi;
  logic                         acc_ovf;
  logic                         sat_d;
  logic                         sat_q;

  // acc fits the signed OUT_WIDTH range exactly when every bit from the
  // output sign position upward is equal.
  assign acc_hi  = acc_d[ACC_WIDTH-1:OUT_WIDTH-1];
  assign acc_ovf = ~((&acc_hi) | ~(|acc_hi));

  always_comb begin
    out_red = acc_d[OUT_WIDTH-1:0];
    if (acc_ovf) begin
      if (acc_d[ACC_WIDTH-1]) out_red = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else                    out_red = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    sat_d = sat_q;
    if (emit) sat_d = acc_ovf;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sat_q <= 1'b0;
    end else if (enable) begin
      sat_q <= sat_d;
    end
  end

  assign out_sat = sat_q;
`else
  assign out_red = acc_d[OUT_WIDTH-1:0];
  assign out_sat = 1'b0;
`endif

  always_comb begin
    out_d = out_q;
    if (emit) out_d = out_red;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (enable) begin
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= emit;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule : adder_tree_acc_pipe

// File: tb/tb_adder_tree_acc_pipe.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_adder_tree_acc_pipe
//   Two instances share one stimulus stream: dut_a (OUT_WIDTH=32) and dut_b
//   (OUT_WIDTH=16, where clamp/wrap behaviour shows up). The reference model
//   keeps the running sum as a plain integer and pushes one expectation per
//   completed sum; a negedge monitor pops and compares value, out_sat and
//   latency in enabled cycles.
// -----------------------------------------------------------------------------
module tb_adder_tree_acc_pipe;

  localparam int DW     = 16;
  localparam int TS     = 8;
  localparam int AW     = 48;
  localparam int OW_A   = 32;
  localparam int OW_B   = 16;
  localparam int LEVELS = 3;
  localparam int BUS_W  = TS * DW;

  typedef struct {
    logic [AW-1:0] acc;
    int            idx;
  } exp_t;

  typedef int lanes_t[TS];

  // ---------------------------------------------------------------- signals
  logic             clock;
  logic             reset;
  logic             enable;
  logic             in_valid;
  logic             in_first;
  logic             in_last;
  logic [BUS_W-1:0] in_bus;
  logic             out_valid_a;
  logic [OW_A-1:0]  out_a;
  logic             out_sat_a;
  logic             out_valid_b;
  logic [OW_B-1:0]  out_b;
  logic             out_sat_b;

  exp_t   exp_a_q[$];
  exp_t   exp_b_q[$];
  longint model_acc;
  int     en_cnt;
  logic   edge_en;
  int     n_checks;
  int     n_pass;

  // ---------------------------------------------------------------- DUTs
  adder_tree_acc_pipe #(
    .DATA_WIDTH (DW), .TREE_SIZE (TS), .ACC_WIDTH (AW), .OUT_WIDTH (OW_A)
  ) dut_a (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .in        (in_bus),
    .out_valid (out_valid_a),
    .out       (out_a),
    .out_sat   (out_sat_a)
  );

  adder_tree_acc_pipe #(
    .DATA_WIDTH (DW), .TREE_SIZE (TS), .ACC_WIDTH (AW), .OUT_WIDTH (OW_B)
  ) dut_b (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .in        (in_bus),
    .out_valid (out_valid_b),
    .out       (out_b),
    .out_sat   (out_sat_b)
  );

  // ---------------------------------------------------------------- clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counts accepted (enabled, out of reset) rising edges; latency is measured
  // in this unit so stalls do not count.
  always @(posedge clock) begin
    edge_en <= reset && enable;
    if (reset && enable) en_cnt <= en_cnt + 1;
  end

  // ---------------------------------------------------------------- model
  function automatic longint wrap_acc(input longint v);
    longint t;
    t = v <<< (64 - AW);
    return t >>> (64 - AW);
  endfunction

  function automatic longint lane_sum(input logic [BUS_W-1:0] bus);
    longint s;
    logic signed [DW-1:0] x;
    s = 0;
    for (int i = 0; i < TS; i++) begin
      x = bus[i*DW +: DW];
      s = s + longint'(x);
    end
    return s;
  endfunction

  // Returns {sat, value} for an accumulator value reduced to ow bits.
  function automatic logic [32:0] reduce(input logic [AW-1:0] acc, input int ow);
    longint      v;
    longint      mx;
    longint      mn;
    logic [31:0] mask;
    v    = longint'($signed(acc));
    mx   = (longint'(1) <<< (ow - 1)) - 1;
    mn   = -mx - 1;
    mask = (ow >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ow) - 32'd1);
`ifdef ADDER_TREE_ACC_SAT_EN
    if (v > mx) return {1'b1, 32'(mx) & mask};
    if (v < mn) return {1'b1, 32'(mn) & mask};
`endif
    return {1'b0, 32'(v) & mask};
  endfunction

  function automatic logic [BUS_W-1:0] pack(input lanes_t v);
    logic [BUS_W-1:0] b;
    for (int i = 0; i < TS; i++) b[i*DW +: DW] = DW'(v[i]);
    return b;
  endfunction

  function automatic logic [BUS_W-1:0] rand_bus();
    logic [BUS_W-1:0] b;
    int               mode;
    mode = $urandom_range(0, 2);
    for (int i = 0; i < TS; i++) begin
      case (mode)
        0:       b[i*DW +: DW] = DW'($urandom_range(0, 200)) - DW'(100);
        1:       b[i*DW +: DW] = DW'($urandom);
        default: b[i*DW +: DW] = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
      endcase
    end
    return b;
  endfunction

  // ---------------------------------------------------------------- checking
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic check_out(input string tag, input logic [OW_A-1:0] o, input logic s,
                           input int ow, inout exp_t q[$]);
    exp_t        e;
    logic [32:0] r;
    if (q.size() == 0) begin
      check({tag, "_unexpected_valid"}, 64'd1, 64'd0);
    end else begin
      e = q.pop_front();
      r = reduce(e.acc, ow);
      check({tag, "_out"}, 64'(o), 64'(r[31:0]));
      check({tag, "_sat"}, 64'(s), 64'(r[32]));
      check({tag, "_latency"}, 64'(en_cnt), 64'(e.idx + LEVELS + 1));
    end
  endtask

  always @(negedge clock) begin
    if (reset && edge_en) begin
      if (out_valid_a) check_out("a", out_a, out_sat_a, OW_A, exp_a_q);
      if (out_valid_b) check_out("b", OW_A'(out_b), out_sat_b, OW_B, exp_b_q);
    end
  end

  // ---------------------------------------------------------------- driver
  // Called at a negedge; presents one cycle of inputs and returns at the next
  // negedge. Only beats the DUT will accept update the model.
  task automatic issue(input logic [BUS_W-1:0] bus, input logic v, input logic f,
                       input logic l);
    longint s;
    exp_t   e;
    in_bus   = bus;
    in_valid = v;
    in_first = f;
    in_last  = l;
    if (v && enable) begin
      s = lane_sum(bus);
      model_acc = f ? s : wrap_acc(model_acc + s);
      if (l) begin
        e.acc = AW'(model_acc);
        e.idx = en_cnt;
        exp_a_q.push_back(e);
        exp_b_q.push_back(e);
      end
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue('0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic stall(input int n);
    enable = 1'b0;
    for (int i = 0; i < n; i++) issue(rand_bus(), 1'b1, 1'b1, 1'b1);
    enable = 1'b1;
  endtask

  // Reset lands just after the negedge so the monitor has already handled
  // this cycle's outputs; everything in flight is dropped from the model.
  task automatic pulse_reset();
    #2;
    reset     = 1'b0;
    in_valid  = 1'b0;
    exp_a_q.delete();
    exp_b_q.delete();
    model_acc = 0;
    @(negedge clock);
    @(negedge clock);
    check("rst_mid_valid_a", 64'(out_valid_a), 64'd0);
    check("rst_mid_out_a",   64'(out_a),       64'd0);
    check("rst_mid_out_b",   64'(out_b),       64'd0);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    reset     = 1'b0;
    enable    = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_bus    = '0;
    model_acc = 0;
    en_cnt    = 0;
    edge_en   = 1'b0;
    n_checks  = 0;
    n_pass    = 0;

    @(negedge clock);
    @(negedge clock);
    check("rst_valid_a", 64'(out_valid_a), 64'd0);
    check("rst_out_a",   64'(out_a),       64'd0);
    check("rst_sat_a",   64'(out_sat_a),   64'd0);
    check("rst_valid_b", 64'(out_valid_b), 64'd0);
    check("rst_out_b",   64'(out_b),       64'd0);
    check("rst_sat_b",   64'(out_sat_b),   64'd0);
    reset = 1'b1;
    @(negedge clock);

    // Single-beat sums: 210, -31, 38 back to back.
    issue(pack('{1, 2, 3, 4, 120, 6, 66, 8}), 1'b1, 1'b1, 1'b1);
    issue(pack('{0, 2, -40, 4, 7, -13, 7, 2}), 1'b1, 1'b1, 1'b1);
    issue(pack('{5, 5, 5, 5, 5, 5, 5, 3}), 1'b1, 1'b1, 1'b1);
    idle(6);

    // Multi-beat with a bubble: 36 + 80 = 116.
    issue(pack('{1, 2, 3, 4, 5, 6, 7, 8}), 1'b1, 1'b1, 1'b0);
    idle(1);
    issue(pack('{10, 10, 10, 10, 10, 10, 10, 10}), 1'b1, 1'b0, 1'b1);
    // Partial sum discarded by a new first: only 210 comes out.
    issue(pack('{100, 100, 100, 100, 100, 100, 100, 100}), 1'b1, 1'b1, 1'b0);
    issue(pack('{1, 2, 3, 4, 120, 6, 66, 8}), 1'b1, 1'b1, 1'b1);
    idle(6);

    // Stall with two beats in flight.
    issue(pack('{-7, 3, 9, -1, 0, 22, -30, 4}), 1'b1, 1'b1, 1'b1);
    issue(pack('{1, 1, 1, 1, 1, 1, 1, 1}), 1'b1, 1'b1, 1'b1);
    stall(3);
    idle(6);

    // Reset with beats in flight, then last-without-first onto a cleared acc.
    issue(pack('{3, 3, 3, 3, 3, 3, 3, 3}), 1'b1, 1'b1, 1'b1);
    issue(pack('{9, 9, 9, 9, 9, 9, 9, 9}), 1'b1, 1'b1, 1'b0);
    pulse_reset();
    issue(pack('{2, 4, 6, 8, -1, -3, -5, -7}), 1'b1, 1'b0, 1'b1);
    issue(pack('{1, 2, 3, 4, 120, 6, 66, 8}), 1'b1, 1'b1, 1'b1);
    idle(6);

    // 8 x 10000 = 80000: exceeds the 16-bit output range.
    issue(pack('{10000, 10000, 10000, 10000, 10000, 10000, 10000, 10000}), 1'b1, 1'b1, 1'b1);
    issue(pack('{-20000, -20000, -20000, -20000, -20000, -20000, -20000, -20000}),
          1'b1, 1'b1, 1'b1);
    idle(6);

    // Randomized traffic with random stalls.
    for (int n = 0; n < 400; n++) begin
      enable = ($urandom_range(0, 7) != 0);
      issue(rand_bus(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0));
    end
    enable = 1'b1;

    // Drain with a bounded wait.
    for (int n = 0; n < 40 && (exp_a_q.size() != 0 || exp_b_q.size() != 0); n++) idle(1);
    check("drain_a_pending", 64'(exp_a_q.size()), 64'd0);
    check("drain_b_pending", 64'(exp_b_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_adder_tree_acc_pipe
